// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pooling stage.
package pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  function automatic logic [LANE_W-1:0] smax8(input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/lane_max4.sv
// Four independent signed int8 max accumulators; the tag-0 datum seeds the window.
// pooled is the combinational window result including the current datum, with optional ReLU.
module lane_max4
  import pool_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [1:0]              tag,
  input  logic                    relu_en,
  input  logic [LANES*LANE_W-1:0] data,
  output logic [LANES*LANE_W-1:0] pooled
);

  logic [LANES*LANE_W-1:0] acc;
  logic [LANES*LANE_W-1:0] merged;

  always_comb begin
    merged = '0;
    pooled = '0;
    for (int i = 0; i < LANES; i++) begin
      merged[i*LANE_W +: LANE_W] = (tag == 2'd0) ? data[i*LANE_W +: LANE_W]
                                 : smax8(acc[i*LANE_W +: LANE_W], data[i*LANE_W +: LANE_W]);
      pooled[i*LANE_W +: LANE_W] = (relu_en && merged[i*LANE_W + LANE_W - 1]) ? '0
                                 : merged[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (valid) begin
      acc <= merged;
    end
  end

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a packed int8 feature map (4 channels per word).
// Reads stream back-to-back, one pooled word is written every 4 cycles.
module maxpool_2x2
  import pool_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_cg,
  input  logic              relu_en,
  output logic              Msrc_en,
  output logic [ADDR_W-1:0] Msrc_addr,
  input  logic [31:0]       Msrc_R_data,
  output logic              Mdst_en,
  output logic [ADDR_W-1:0] Mdst_addr,
  output logic [3:0]        Mdst_W_req,
  output logic [31:0]       Mdst_W_data
);

  // Word indices span cg*H*W, so the counters carry three dimension widths.
  localparam int CW = 3 * DIM_W;

  state_t state_q, state_d;

  logic [DIM_W-1:0] w_q, h_q, cg_q;
  logic             relu_q;
  logic [DIM_W-1:0] ow, oh;
  logic [DIM_W-1:0] ox, oy, g;
  logic [1:0]       p;
  logic [CW-1:0]    row_base, x2, dst_cnt, rd_word, w_ext;
  logic             dv_d;
  logic [1:0]       tag_d;
  logic             fl_cnt;
  logic             empty, last_ox, last_oy, last_g, last_rd;
  logic [31:0]      pooled;

  assign ow      = {1'b0, w_q[DIM_W-1:1]};
  assign oh      = {1'b0, h_q[DIM_W-1:1]};
  assign w_ext   = CW'(w_q);
  assign empty   = (cfg_w < DIM_W'(2)) || (cfg_h < DIM_W'(2)) || (cfg_cg == '0);
  assign last_ox = (ox == ow - DIM_W'(1));
  assign last_oy = (oy == oh - DIM_W'(1));
  assign last_g  = (g == cg_q - DIM_W'(1));
  assign last_rd = (state_q == S_RUN) && (p == 2'd3) && last_ox && last_oy && last_g;

  assign rd_word   = row_base + x2 + CW'(p[0]) + (p[1] ? w_ext : '0);
  assign Msrc_addr = ADDR_W'({rd_word, 2'b00});
  assign Msrc_en   = 1'b1;
  assign Mdst_en   = 1'b1;
  assign finish    = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = empty ? S_DONE : S_RUN;
      S_RUN:   if (last_rd) state_d = S_FLUSH;
      S_FLUSH: if (fl_cnt) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0; h_q <= '0; cg_q <= '0; relu_q <= 1'b0;
      ox <= '0; oy <= '0; g <= '0; p <= '0;
      row_base <= '0; x2 <= '0; dst_cnt <= '0;
      dv_d <= 1'b0; tag_d <= '0; fl_cnt <= 1'b0;
      Mdst_W_req <= '0; Mdst_addr <= '0; Mdst_W_data <= '0;
    end else begin
      dv_d   <= (state_q == S_RUN);
      tag_d  <= p;
      fl_cnt <= (state_q == S_FLUSH);
      if (state_q == S_IDLE && start) begin
        w_q <= cfg_w; h_q <= cfg_h; cg_q <= cfg_cg; relu_q <= relu_en;
        ox <= '0; oy <= '0; g <= '0; p <= '0;
        row_base <= '0; x2 <= '0; dst_cnt <= '0;
      end else if (state_q == S_RUN) begin
        p <= p + 2'd1;
        if (p == 2'd3) begin
          if (!last_ox) begin
            ox <= ox + DIM_W'(1);
            x2 <= x2 + CW'(2);
          end else begin
            ox <= '0;
            x2 <= '0;
            if (!last_oy) begin
              oy       <= oy + DIM_W'(1);
              row_base <= row_base + (w_ext << 1);
            end else begin
              // Skip the dropped odd row to land on the next group's first row.
              oy       <= '0;
              g        <= g + DIM_W'(1);
              row_base <= row_base + (w_ext << 1) + (h_q[0] ? w_ext : '0);
            end
          end
        end
      end
      if (dv_d && tag_d == 2'd3) begin
        Mdst_W_req  <= 4'hF;
        Mdst_W_data <= pooled;
        Mdst_addr   <= ADDR_W'({dst_cnt, 2'b00});
        dst_cnt     <= dst_cnt + CW'(1);
      end else begin
        Mdst_W_req <= '0;
      end
    end
  end

  lane_max4 u_lane_max4 (
    .clk     (clk),
    .rst     (rst),
    .valid   (dv_d),
    .tag     (tag_d),
    .relu_en (relu_q),
    .data    (Msrc_R_data),
    .pooled  (pooled)
  );

endmodule
